// File: rtl/rdm_combine_fsm_p.sv
// Rate-dematching read/combine sequencer: reads E soft bits and emits circular-buffer write beats.
// Optional build macro RDM_LLR_CLIP_EN folds the most negative LLR onto its symmetric neighbour.
module rdm_combine_fsm_p #(
  parameter int LANES  = 32,
  parameter int LLR_W  = 6,
  parameter int E_W    = 14,
  parameter int NCB_W  = 16,
  parameter int ADDR_W = 16,
  parameter int USER_W = 4
) (
  input  logic                    i_core_clk,
  input  logic                    i_rx_rstn,
  input  logic                    i_Combine_process_request,
  input  logic                    i_RDM_Data_Request,
  input  logic [E_W-1:0]          i_Current_Combine_E01_Size,
  input  logic [NCB_W-1:0]        i_Current_Combine_Ncb_Size,
  input  logic [USER_W-1:0]       i_Combine_user_index,
  output logic [ADDR_W-1:0]       o_Input_Buffer_Offset_Address,
  output logic                    o_Input_Buffer_RDM_Data_Enable,
  input  logic [LANES*LLR_W-1:0]  i_Input_Buffer_RDM_Data_ALL,
  output logic                    o_cb_valid,
  output logic [NCB_W-1:0]        o_cb_addr,
  output logic [LANES*LLR_W-1:0]  o_cb_data,
  output logic [LANES-1:0]        o_cb_mask,
  output logic                    o_cb_combine,
  output logic [USER_W-1:0]       o_cb_user,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int DW = LANES * LLR_W;
  localparam int CW = ((E_W > NCB_W) ? E_W : NCB_W) + 1;
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  typedef enum logic [1:0] {IDLE, READ, DATA, EMIT_A} state_t;

  state_t state, state_n;

  logic              req_d;
  logic [NCB_W-1:0]  ncb_q;
  logic [USER_W-1:0] user_q;
  logic [NCB_W-1:0]  pos;
  logic [E_W-1:0]    rem;
  logic              wrap;
  logic [ADDR_W-1:0] addr;
  logic [DW-1:0]     word_q;

  logic              rd_en, start, beat_a, beat_b, finish;
  logic              bad_ncb, rise;
  logic [CW-1:0]     rem_x, n, r, lanes_a, over;
  logic              split, last;
  logic [DW-1:0]     word_hi;

  function automatic logic [LLR_W-1:0] clip_lane(input logic [LLR_W-1:0] v);
    logic [LLR_W-1:0] most_neg;
    most_neg = '0;
    most_neg[LLR_W-1] = 1'b1;
`ifdef RDM_LLR_CLIP_EN
    if (v == most_neg) return most_neg | LLR_W'(1);
    return v;
`else
    return v | (most_neg & ~most_neg);
`endif
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [CW-1:0] cnt);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (CW'(i) < cnt);
    return m;
  endfunction

  function automatic logic [DW-1:0] pack_lanes(input logic [DW-1:0] w, input logic [LANES-1:0] m);
    logic [DW-1:0] o;
    o = '0;
    for (int i = 0; i < LANES; i++)
      if (m[i]) o[i*LLR_W +: LLR_W] = clip_lane(w[i*LLR_W +: LLR_W]);
    return o;
  endfunction

  // Lane accounting for the current word: n lanes remain to be placed, r positions before the wrap.
  assign rem_x   = CW'(rem);
  assign n       = (rem_x < LANES_C) ? rem_x : LANES_C;
  assign r       = CW'(ncb_q) - CW'(pos);
  assign lanes_a = (n < r) ? n : r;
  assign over    = n - r;
  assign split   = (n > r);
  assign last    = (rem_x == n);
  assign word_hi = word_q >> (32'(r) * LLR_W);

  assign bad_ncb = (CW'(i_Current_Combine_Ncb_Size) < LANES_C);
  assign rise    = i_Combine_process_request && !req_d;

  assign o_Input_Buffer_Offset_Address  = addr;
  assign o_Input_Buffer_RDM_Data_Enable = rd_en;
  assign o_busy                         = (state != IDLE);

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    start   = 1'b0;
    beat_a  = 1'b0;
    beat_b  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          start = 1'b1;
          if (!bad_ncb && (i_Current_Combine_E01_Size != '0)) state_n = READ;
        end
      end
      READ: begin
        if (!i_Combine_process_request) state_n = IDLE;
        else if (i_RDM_Data_Request) begin
          rd_en   = 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        if (!i_Combine_process_request) state_n = IDLE;
        else begin
          beat_a = 1'b1;
          if (split) state_n = EMIT_A;
          else begin
            finish  = 1'b1;
            state_n = last ? IDLE : READ;
          end
        end
      end
      EMIT_A: begin
        // Beat A is on the output now; the wrapped remainder is registered as beat B here.
        if (!i_Combine_process_request) state_n = IDLE;
        else begin
          beat_b  = 1'b1;
          finish  = 1'b1;
          state_n = last ? IDLE : READ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      req_d        <= 1'b0;
      ncb_q        <= '0;
      user_q       <= '0;
      pos          <= '0;
      rem          <= '0;
      wrap         <= 1'b0;
      addr         <= '0;
      word_q       <= '0;
      o_cb_valid   <= 1'b0;
      o_cb_addr    <= '0;
      o_cb_data    <= '0;
      o_cb_mask    <= '0;
      o_cb_combine <= 1'b0;
      o_cb_user    <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      req_d      <= i_Combine_process_request;
      o_cb_valid <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      if (start) begin
        ncb_q     <= i_Current_Combine_Ncb_Size;
        user_q    <= i_Combine_user_index;
        o_cb_user <= i_Combine_user_index;
        pos       <= '0;
        rem       <= i_Current_Combine_E01_Size;
        wrap      <= 1'b0;
        addr      <= '0;
        if (bad_ncb) begin
          o_err  <= 1'b1;
          o_done <= 1'b1;
        end else if (i_Current_Combine_E01_Size == '0) begin
          o_done <= 1'b1;
        end
      end
      if (beat_a) begin
        word_q       <= i_Input_Buffer_RDM_Data_ALL;
        o_cb_valid   <= 1'b1;
        o_cb_addr    <= pos;
        o_cb_mask    <= lane_mask(lanes_a);
        o_cb_data    <= pack_lanes(i_Input_Buffer_RDM_Data_ALL, lane_mask(lanes_a));
        o_cb_combine <= wrap;
        o_cb_user    <= user_q;
      end
      if (beat_b) begin
        o_cb_valid   <= 1'b1;
        o_cb_addr    <= '0;
        o_cb_mask    <= lane_mask(over);
        o_cb_data    <= pack_lanes(word_hi, lane_mask(over));
        o_cb_combine <= 1'b1;
        o_cb_user    <= user_q;
      end
      if (finish) begin
        rem  <= rem - n[E_W-1:0];
        addr <= addr + ADDR_W'(1);
        if (n < r) begin
          pos <= pos + n[NCB_W-1:0];
        end else if (n == r) begin
          pos  <= '0;
          wrap <= 1'b1;
        end else begin
          pos  <= over[NCB_W-1:0];
          wrap <= 1'b1;
        end
        if (last) o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rdm_combine_fsm_p.sv
// Scoreboard bench for rdm_combine_fsm_p: a per-soft-bit circular-buffer model predicts every beat.
// Build with RDM_LLR_CLIP_EN defined to exercise the clipped build.
module tb_rdm_combine_fsm_p;

  typedef struct packed {
    logic [15:0]  addr;
    logic [31:0]  mask;
    logic [191:0] data;
    logic         comb;
    logic [3:0]   user;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         combReq = 1'b0;
  logic         dataReq = 1'b1;
  logic [13:0]  eSize = '0;
  logic [15:0]  ncbSize = '0;
  logic [3:0]   userIdx = '0;
  logic [15:0]  rdAddr;
  logic         rdEn;
  logic [191:0] rdData = '0;
  logic         cbValid;
  logic [15:0]  cbAddr;
  logic [191:0] cbData;
  logic [31:0]  cbMask;
  logic         cbComb;
  logic [3:0]   cbUser;
  logic         busy, done, err;

  logic [191:0] mem [64];
  beat_t        expQ [$];

  int checks = 0;
  int failures = 0;
  int expRdAddr = 0;
  int strobeCnt = 0;
  int beatCnt = 0;
  int beatTotal = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int bothCnt = 0;
  int stallAt = 0;
  int stallLeft = 0;
  int abortAt = 0;
  logic [5:0] firstLane0 = '0;

  rdm_combine_fsm_p dut (
    .i_core_clk                     (clk),
    .i_rx_rstn                      (rstN),
    .i_Combine_process_request      (combReq),
    .i_RDM_Data_Request             (dataReq),
    .i_Current_Combine_E01_Size     (eSize),
    .i_Current_Combine_Ncb_Size     (ncbSize),
    .i_Combine_user_index           (userIdx),
    .o_Input_Buffer_Offset_Address  (rdAddr),
    .o_Input_Buffer_RDM_Data_Enable (rdEn),
    .i_Input_Buffer_RDM_Data_ALL    (rdData),
    .o_cb_valid                     (cbValid),
    .o_cb_addr                      (cbAddr),
    .o_cb_data                      (cbData),
    .o_cb_mask                      (cbMask),
    .o_cb_combine                   (cbComb),
    .o_cb_user                      (cbUser),
    .o_busy                         (busy),
    .o_done                         (done),
    .o_err                          (err)
  );

  always #5 clk = ~clk;

  // Input buffer: one-cycle read latency
  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr[5:0]];

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] refClip(input logic [5:0] v);
`ifdef RDM_LLR_CLIP_EN
    return (v == 6'h20) ? 6'h21 : v;
`else
    return v;
`endif
  endfunction

  // Soft bit e lands at k = e mod Ncb; a beat runs until the word ends or k wraps to 0.
  task automatic pushExpected(input int eSz, input int ncb, input int user, input int maxBeats);
    int pushed;
    pushed = 0;
    for (int w = 0; w * 32 < eSz; w++) begin
      int n;
      int j;
      logic [191:0] word;
      n = (eSz - w * 32 < 32) ? eSz - w * 32 : 32;
      j = 0;
      word = mem[w % 64];
      while (j < n) begin
        int e;
        int k;
        int len;
        beat_t b;
        logic [63:0] m;
        e = w * 32 + j;
        k = e % ncb;
        len = (n - j < ncb - k) ? n - j : ncb - k;
        m = (64'(1) << len) - 64'(1);
        b.addr = 16'(k);
        b.mask = m[31:0];
        b.data = '0;
        for (int t = 0; t < len; t++) b.data[t*6 +: 6] = refClip(word[(j+t)*6 +: 6]);
        b.comb = (e >= ncb);
        b.user = 4'(user);
        if (maxBeats == 0 || pushed < maxBeats) begin
          expQ.push_back(b);
          pushed++;
        end
        j += len;
      end
    end
  endtask

  // Monitor: strobes, beats, pulses, plus the data-request stall and abort injection
  always @(negedge clk) begin
    if (rdEn) begin
      checkOutput("rd_strobe_while_req_high", 256'(dataReq), 256'(1));
      checkOutput("rd_addr", 256'(rdAddr), 256'(expRdAddr));
      expRdAddr++;
      strobeCnt++;
    end
    if (cbValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat", 256'(1), 256'(0));
      end else begin
        beat_t b;
        b = expQ.pop_front();
        checkOutput("beat_addr", 256'(cbAddr), 256'(b.addr));
        checkOutput("beat_mask", 256'(cbMask), 256'(b.mask));
        checkOutput("beat_data", 256'(cbData), 256'(b.data));
        checkOutput("beat_combine", 256'(cbComb), 256'(b.comb));
        checkOutput("beat_user", 256'(cbUser), 256'(b.user));
      end
      if (beatTotal == 0) firstLane0 = cbData[5:0];
      beatTotal++;
      beatCnt++;
      if (abortAt != 0 && beatCnt == abortAt) combReq = 1'b0;
    end
    if (done) doneCnt++;
    if (err) errCnt++;
    if (done && err) bothCnt++;
    if (stallLeft > 0) begin
      stallLeft--;
      if (stallLeft == 0) dataReq = 1'b1;
    end else if (rdEn && stallAt != 0 && strobeCnt == stallAt) begin
      dataReq = 1'b0;
      stallLeft = 10;
    end
  end

  task automatic applyStimulus(input int eSz, input int ncb, input int user,
                               input int stall, input int abortBeat, input int readsOverride);
    int d0, e0, b0, s0, expReads;
    logic isErr, seen;
    expRdAddr = 0;
    strobeCnt = 0;
    beatCnt = 0;
    d0 = doneCnt;
    e0 = errCnt;
    b0 = bothCnt;
    isErr = (ncb < 32);
    if (!isErr) pushExpected(eSz, ncb, user, abortBeat);
    expReads = (isErr || eSz == 0) ? 0 : (eSz + 31) / 32;
    if (readsOverride >= 0) expReads = readsOverride;
    eSize = 14'(eSz);
    ncbSize = 16'(ncb);
    userIdx = 4'(user);
    stallAt = stall;
    abortAt = abortBeat;
    combReq = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (abortBeat != 0 ? (beatCnt >= abortBeat) : (doneCnt != d0)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("finish_seen", 256'(seen), 256'(1));
    repeat (5) @(negedge clk);
    #1;
    checkOutput("queue_drained", 256'(expQ.size()), 256'(0));
    expQ.delete();
    checkOutput("done_pulses", 256'(doneCnt - d0), (abortBeat != 0) ? 256'(0) : 256'(1));
    checkOutput("err_pulses", 256'(errCnt - e0), 256'(isErr));
    checkOutput("err_with_done", 256'(bothCnt - b0), 256'(isErr));
    checkOutput("read_count", 256'(strobeCnt), 256'(expReads));
    checkOutput("busy_after", 256'(busy), 256'(0));
    if (abortBeat == 0) begin
      s0 = strobeCnt;
      d0 = doneCnt;
      repeat (10) @(negedge clk);
      #1;
      checkOutput("no_restart_strobes", 256'(strobeCnt), 256'(s0));
      checkOutput("no_restart_done", 256'(doneCnt), 256'(d0));
      checkOutput("no_restart_busy", 256'(busy), 256'(0));
    end
    combReq = 1'b0;
    abortAt = 0;
    stallAt = 0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    for (int w = 0; w < 64; w++)
      for (int l = 0; l < 32; l++) mem[w][l*6 +: 6] = 6'($urandom_range(0, 63));
    mem[0][5:0] = 6'h20;
    mem[3][17:12] = 6'h20;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_cb_data", 256'(cbData), 256'(0));
    checkOutput("reset_ctrl", 256'({rdAddr, rdEn, cbValid, cbAddr, cbMask, cbComb, cbUser, busy, done, err}), 256'(0));
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    $display("[TB] E=129 Ncb=110 wrap inside word 3");
    applyStimulus(129, 110, 3, 0, 0, -1);
`ifdef RDM_LLR_CLIP_EN
    checkOutput("clip_lane0", 256'(firstLane0), 256'(6'h21));
`else
    checkOutput("clip_lane0", 256'(firstLane0), 256'(6'h20));
`endif
    $display("[TB] E=64 Ncb=64 exact fit");
    applyStimulus(64, 64, 5, 0, 0, -1);
    $display("[TB] Ncb=20 below lane count");
    applyStimulus(100, 20, 1, 0, 0, -1);
    $display("[TB] E=0");
    applyStimulus(0, 100, 2, 0, 0, -1);
    $display("[TB] data request stall after 2nd read");
    applyStimulus(129, 110, 3, 2, 0, -1);
    $display("[TB] abort while beat A is out");
    applyStimulus(129, 110, 7, 0, 4, 4);
    $display("[TB] restart after abort");
    applyStimulus(129, 110, 9, 0, 0, -1);
    $display("[TB] Ncb=32 boundary");
    applyStimulus(100, 32, 4, 0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      int ncbR, eR;
      ncbR = int'($urandom_range(32, 300));
      eR = int'($urandom_range(1, 600));
      $display("[TB] random E=%0d Ncb=%0d", eR, ncbR);
      applyStimulus(eR, ncbR, i + 10, 0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
